// File: rtl/hsv_core_commit.sv
// Commit stage: round-robin arbiter of four result channels onto one register-file write port, one commit per cycle, outputs registered one cycle after the transfer.
// Backpressure: only the granted channel sees ready; during a flush cycle every channel is ready and its result is dropped.
module hsv_core_commit #(
   parameter int REG_COUNT = 32
) (
   input  logic                 clk_core,
   input  logic                 rst_core_n,
   input  logic                 alu_valid_i,
   output logic                 alu_ready_o,
   input  logic [4:0]           alu_rd,
   input  logic [31:0]          alu_rd_value,
   input  logic                 branch_valid_i,
   output logic                 branch_ready_o,
   input  logic [4:0]           branch_rd,
   input  logic [31:0]          branch_rd_value,
   input  logic                 branch_taken,
   input  logic [31:0]          branch_target,
   input  logic                 ctrl_status_valid_i,
   output logic                 ctrl_status_ready_o,
   input  logic [4:0]           ctrl_status_rd,
   input  logic [31:0]          ctrl_status_rd_value,
   input  logic                 mem_valid_i,
   output logic                 mem_ready_o,
   input  logic [4:0]           mem_rd,
   input  logic [31:0]          mem_rd_value,
   output logic                 wr_en_o,
   output logic [4:0]           wr_addr_o,
   output logic [31:0]          wr_data_o,
   output logic [REG_COUNT-1:0] release_mask_o,
   output logic                 flush_req_o,
   output logic [31:0]          flush_pc_o
);

   logic [1:0]           rr_ptr_q, rr_ptr_d;
   logic                 wr_en_q, wr_en_d;
   logic [4:0]           wr_addr_q, wr_addr_d;
   logic [31:0]          wr_data_q, wr_data_d;
   logic [REG_COUNT-1:0] release_mask_q, release_mask_d;
   logic                 flush_req_q, flush_req_d;
   logic [31:0]          flush_pc_q, flush_pc_d;

   logic [3:0]  vld;
   logic [3:0]  rdy;
   logic        grant_vld;
   logic [1:0]  grant_idx;
   logic [1:0]  scan_idx;
   logic        commit;
   logic [4:0]  sel_rd;
   logic [31:0] sel_val;

   assign vld = {mem_valid_i, ctrl_status_valid_i, branch_valid_i, alu_valid_i};

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = rr_ptr_q;
      scan_idx  = rr_ptr_q;
      for (int k = 0; k < 4; k++) begin
         scan_idx = rr_ptr_q + 2'(k);
         if (!grant_vld && vld[scan_idx]) begin
            grant_vld = 1'b1;
            grant_idx = scan_idx;
         end
      end
   end

   // A flush cycle swallows every wrong-path result and suppresses the grant.
   assign commit = grant_vld & ~flush_req_q;

   always_comb begin
      rdy = 4'b0000;
      if (flush_req_q) begin
         rdy = 4'b1111;
      end else if (grant_vld) begin
         rdy = 4'b0001 << grant_idx;
      end
   end

   assign alu_ready_o         = rdy[0];
   assign branch_ready_o      = rdy[1];
   assign ctrl_status_ready_o = rdy[2];
   assign mem_ready_o         = rdy[3];

   always_comb begin
      sel_rd  = alu_rd;
      sel_val = alu_rd_value;
      case (grant_idx)
         2'd1: begin sel_rd = branch_rd;      sel_val = branch_rd_value;      end
         2'd2: begin sel_rd = ctrl_status_rd; sel_val = ctrl_status_rd_value; end
         2'd3: begin sel_rd = mem_rd;         sel_val = mem_rd_value;         end
         default: begin sel_rd = alu_rd;      sel_val = alu_rd_value;         end
      endcase
   end

   always_comb begin
      rr_ptr_d       = rr_ptr_q;
      wr_en_d        = 1'b0;
      wr_addr_d      = wr_addr_q;
      wr_data_d      = wr_data_q;
      release_mask_d = '0;
      flush_req_d    = 1'b0;
      flush_pc_d     = flush_pc_q;
      if (commit) begin
         rr_ptr_d       = grant_idx + 2'd1;
         wr_en_d        = (sel_rd != 5'd0);
         wr_addr_d      = sel_rd;
         wr_data_d      = sel_val;
         release_mask_d = {{(REG_COUNT-1){1'b0}}, 1'b1} << sel_rd;
         if (grant_idx == 2'd1 && branch_taken) begin
            flush_req_d = 1'b1;
            flush_pc_d  = branch_target;
         end
      end
   end

   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
         rr_ptr_q       <= 2'd0;
         wr_en_q        <= 1'b0;
         wr_addr_q      <= 5'd0;
         wr_data_q      <= 32'd0;
         release_mask_q <= '0;
         flush_req_q    <= 1'b0;
         flush_pc_q     <= 32'd0;
      end else begin
         rr_ptr_q       <= rr_ptr_d;
         wr_en_q        <= wr_en_d;
         wr_addr_q      <= wr_addr_d;
         wr_data_q      <= wr_data_d;
         release_mask_q <= release_mask_d;
         flush_req_q    <= flush_req_d;
         flush_pc_q     <= flush_pc_d;
      end
   end

   assign wr_en_o        = wr_en_q;
   assign wr_addr_o      = wr_addr_q;
   assign wr_data_o      = wr_data_q;
   assign release_mask_o = release_mask_q;
   assign flush_req_o    = flush_req_q;
   assign flush_pc_o     = flush_pc_q;

endmodule

// File: tb/tb_hsv_core_commit.sv
// Bench for hsv_core_commit: directed test-plan scenarios plus random producers checked against a transaction-level model.
module tb_hsv_core_commit;

   logic        clk_core = 1'b0;
   logic        rst_core_n = 1'b0;
   logic        alu_valid_i, alu_ready_o;
   logic [4:0]  alu_rd;
   logic [31:0] alu_rd_value;
   logic        branch_valid_i, branch_ready_o;
   logic [4:0]  branch_rd;
   logic [31:0] branch_rd_value;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        ctrl_status_valid_i, ctrl_status_ready_o;
   logic [4:0]  ctrl_status_rd;
   logic [31:0] ctrl_status_rd_value;
   logic        mem_valid_i, mem_ready_o;
   logic [4:0]  mem_rd;
   logic [31:0] mem_rd_value;
   logic        wr_en_o;
   logic [4:0]  wr_addr_o;
   logic [31:0] wr_data_o;
   logic [31:0] release_mask_o;
   logic        flush_req_o;
   logic [31:0] flush_pc_o;

   hsv_core_commit #(.REG_COUNT(32)) dut (
      .clk_core(clk_core), .rst_core_n(rst_core_n),
      .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
      .alu_rd(alu_rd), .alu_rd_value(alu_rd_value),
      .branch_valid_i(branch_valid_i), .branch_ready_o(branch_ready_o),
      .branch_rd(branch_rd), .branch_rd_value(branch_rd_value),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .ctrl_status_valid_i(ctrl_status_valid_i), .ctrl_status_ready_o(ctrl_status_ready_o),
      .ctrl_status_rd(ctrl_status_rd), .ctrl_status_rd_value(ctrl_status_rd_value),
      .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
      .mem_rd(mem_rd), .mem_rd_value(mem_rd_value),
      .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
      .release_mask_o(release_mask_o),
      .flush_req_o(flush_req_o), .flush_pc_o(flush_pc_o)
   );

   always #5 clk_core = ~clk_core;

   int n_checks = 0;
   int n_errors = 0;

   // Producer state: a pending result is held stable until it is accepted.
   bit [3:0]    pend;
   logic [4:0]  rd_a  [4];
   logic [31:0] val_a [4];
   logic        taken;
   logic [31:0] target;
   bit          rand_mode;

   // Reference model state.
   int          m_rr;
   bit          m_flush;
   bit          m_wr_en;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   logic [31:0] m_mask;
   logic [31:0] m_fpc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive();
      alu_valid_i          = pend[0]; alu_rd         = rd_a[0]; alu_rd_value         = val_a[0];
      branch_valid_i       = pend[1]; branch_rd      = rd_a[1]; branch_rd_value      = val_a[1];
      ctrl_status_valid_i  = pend[2]; ctrl_status_rd = rd_a[2]; ctrl_status_rd_value = val_a[2];
      mem_valid_i          = pend[3]; mem_rd         = rd_a[3]; mem_rd_value         = val_a[3];
      branch_taken         = taken;
      branch_target        = target;
   endtask

   task automatic model_reset();
      m_rr = 0; m_flush = 0; m_wr_en = 0; m_addr = 0; m_data = 0; m_mask = 0; m_fpc = 0;
   endtask

   task automatic check_outputs(input string pfx);
      check({pfx, "_wr_en"}, 64'(wr_en_o), 64'(m_wr_en));
      check({pfx, "_wr_addr"}, 64'(wr_addr_o), 64'(m_addr));
      check({pfx, "_wr_data"}, 64'(wr_data_o), 64'(m_data));
      check({pfx, "_mask"}, 64'(release_mask_o), 64'(m_mask));
      check({pfx, "_flush"}, 64'(flush_req_o), 64'(m_flush));
      check({pfx, "_flush_pc"}, 64'(flush_pc_o), 64'(m_fpc));
   endtask

   // One clock cycle: check registered outputs, present inputs, check readys, advance model.
   task automatic step();
      bit [3:0] exp_rdy;
      int       g;
      @(negedge clk_core);
      check_outputs("out");
      if (rand_mode) begin
         for (int c = 0; c < 4; c++) begin
            if (!pend[c] && $urandom_range(0, 1) == 1) begin
               pend[c]  = 1'b1;
               rd_a[c]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
               val_a[c] = $urandom;
               if (c == 1) begin
                  taken  = ($urandom_range(0, 2) == 0);
                  target = $urandom;
               end
            end
         end
      end
      drive();
      #1;
      exp_rdy = 4'b0000;
      g = -1;
      if (m_flush) begin
         exp_rdy = 4'b1111;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (g < 0 && pend[(m_rr + k) % 4]) g = (m_rr + k) % 4;
         end
         if (g >= 0) exp_rdy[g] = 1'b1;
      end
      check("alu_ready", 64'(alu_ready_o), 64'(exp_rdy[0]));
      check("branch_ready", 64'(branch_ready_o), 64'(exp_rdy[1]));
      check("csr_ready", 64'(ctrl_status_ready_o), 64'(exp_rdy[2]));
      check("mem_ready", 64'(mem_ready_o), 64'(exp_rdy[3]));
      m_wr_en = 0;
      m_mask  = 0;
      if (m_flush) begin
         m_flush = 0;
      end else if (g >= 0) begin
         m_wr_en = (rd_a[g] != 0);
         m_addr  = rd_a[g];
         m_data  = val_a[g];
         m_mask  = 32'h1 << rd_a[g];
         m_rr    = (g + 1) % 4;
         if (g == 1 && taken) begin
            m_flush = 1;
            m_fpc   = target;
         end
      end
      pend = pend & ~exp_rdy;
   endtask

   task automatic peek();
      @(posedge clk_core);
      #1;
   endtask

   task automatic do_reset();
      rst_core_n = 1'b0;
      pend = 4'b0000;
      taken = 1'b0;
      drive();
      repeat (2) @(posedge clk_core);
      #1;
      check("rst_wr_en", 64'(wr_en_o), 64'd0);
      check("rst_mask", 64'(release_mask_o), 64'd0);
      check("rst_flush", 64'(flush_req_o), 64'd0);
      check("rst_ready_idle", 64'({alu_ready_o, branch_ready_o, ctrl_status_ready_o, mem_ready_o}), 64'd0);
      model_reset();
      @(posedge clk_core);
      #2;
      rst_core_n = 1'b1;
   endtask

   initial begin
      rand_mode = 0;
      pend = 0; taken = 0; target = 0;
      for (int c = 0; c < 4; c++) begin rd_a[c] = 0; val_a[c] = 0; end
      drive();
      model_reset();
      do_reset();

      // Single ALU commit.
      pend[0] = 1; rd_a[0] = 5'd5; val_a[0] = 32'hDEADBEEF;
      step();
      check("alu1_ready", 64'(alu_ready_o), 64'd1);
      peek();
      check("alu1_wr_en", 64'(wr_en_o), 64'd1);
      check("alu1_addr", 64'(wr_addr_o), 64'd5);
      check("alu1_data", 64'(wr_data_o), 64'hDEADBEEF);
      check("alu1_mask", 64'(release_mask_o), 64'h20);
      step();
      peek();
      check("alu1_idle_wr_en", 64'(wr_en_o), 64'd0);
      check("alu1_idle_mask", 64'(release_mask_o), 64'd0);
      check("alu1_idle_data_hold", 64'(wr_data_o), 64'hDEADBEEF);

      // x0 destination.
      pend[0] = 1; rd_a[0] = 5'd0; val_a[0] = 32'h1234;
      step();
      peek();
      check("x0_wr_en", 64'(wr_en_o), 64'd0);
      check("x0_mask", 64'(release_mask_o), 64'h1);

      // Taken branch with a wrong-path mem result in the same cycle.
      pend[1] = 1; rd_a[1] = 5'd1; val_a[1] = 32'h104; taken = 1; target = 32'h200;
      pend[3] = 1; rd_a[3] = 5'd7; val_a[3] = 32'h777;
      step();
      check("br_granted", 64'(branch_ready_o), 64'd1);
      check("br_mem_held", 64'(mem_ready_o), 64'd0);
      peek();
      check("br_wr_en", 64'(wr_en_o), 64'd1);
      check("br_addr", 64'(wr_addr_o), 64'd1);
      check("br_data", 64'(wr_data_o), 64'h104);
      check("br_flush", 64'(flush_req_o), 64'd1);
      check("br_flush_pc", 64'(flush_pc_o), 64'h200);
      check("br_mem_drop_ready", 64'(mem_ready_o), 64'd1);
      step();
      peek();
      check("br_after_wr_en", 64'(wr_en_o), 64'd0);
      check("br_after_mask", 64'(release_mask_o), 64'd0);
      check("br_after_flush", 64'(flush_req_o), 64'd0);
      check("br_after_pc_hold", 64'(flush_pc_o), 64'h200);
      taken = 0;

      // Round-robin fairness from reset.
      do_reset();
      for (int c = 0; c < 4; c++) begin pend[c] = 1; rd_a[c] = 5'(c + 1); val_a[c] = 32'h100 + c; end
      taken = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         peek();
         check("rr_addr", 64'(wr_addr_o), 64'(i + 1));
         check("rr_mask", 64'(release_mask_o), 64'(32'h1 << (i + 1)));
      end

      // Reset mid-stream.
      do_reset();
      for (int c = 0; c < 4; c++) begin pend[c] = 1; rd_a[c] = 5'(c + 1); val_a[c] = 32'h200 + c; end
      step();
      step();
      #2;
      rst_core_n = 1'b0;
      #1;
      check("mid_rst_wr_en", 64'(wr_en_o), 64'd0);
      check("mid_rst_addr", 64'(wr_addr_o), 64'd0);
      check("mid_rst_data", 64'(wr_data_o), 64'd0);
      check("mid_rst_mask", 64'(release_mask_o), 64'd0);
      model_reset();
      for (int c = 0; c < 4; c++) pend[c] = 1;
      @(posedge clk_core);
      #2;
      rst_core_n = 1'b1;
      step();
      check("mid_rst_first_alu", 64'(alu_ready_o), 64'd1);

      // Random producers against the model.
      rand_mode = 1;
      for (int i = 0; i < 3000; i++) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
